pci: RTL and testbench

PCI -- requirements
Module: pci

---
 rtl/pci_pkg.sv | 27 ++
 rtl/pci_mem.sv | 51 +++++
 rtl/pci.sv | 132 +++++++++++++
 tb/tb_pci.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pci_pkg.sv
// -----------------------------------------------------------------------------
// pci_pkg
// Shared definitions for the PCI memory target: FSM state encoding, the two
// bus commands the target claims, default address window, and a helper
// that sizes the word index into the internal memory.
// -----------------------------------------------------------------------------
package pci_pkg;

    localparam int unsigned DEF_BASE_ADDR = 20;
    localparam int unsigned DEF_DEPTH     = 10;

    localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ_TA,
        ST_READ
    } pci_state_e;

    // Width of a word index into a DEPTH-entry memory (at least one bit).
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pci_mem.sv
// -----------------------------------------------------------------------------
// pci_mem
// DEPTH x 32-bit register file for the PCI target.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high clear of every word
//   we    : write strobe, sampled on the rising edge
//   be    : byte enables, bit i updates byte [8i+7:8i]
//   addr  : word index shared by the write and read ports
//   wdata : write data
//   rdata : asynchronous read of mem[addr]
// -----------------------------------------------------------------------------
module pci_mem
    import pci_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned IDX_W = idx_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_d[addr][8*i +: 8] = wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/pci.sv
// -----------------------------------------------------------------------------
// pci
// Simple PCI memory target claiming word addresses
// [BASE_ADDR, BASE_ADDR+DEPTH-1] for memory read/write bursts.
//   Clock       : rising-edge clock
//   RST         : asynchronous active-high reset
//   Frame       : active-low transaction frame from the initiator
//   AddressData : multiplexed address/data bus, driven only in READ
//   CBE         : command in the address phase, byte enables in data phases
//   Irdy        : active-low initiator ready
//   Devsel      : active-low device select (always driven)
//   Trdy        : active-low target ready (always driven)
// -----------------------------------------------------------------------------
module pci
    import pci_pkg::*;
#(
    parameter int unsigned BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned DEPTH     = DEF_DEPTH
) (
    input  logic        Clock,
    input  logic        RST,
    input  logic        Frame,
    inout  wire  [31:0] AddressData,
    input  logic [3:0]  CBE,
    input  logic        Irdy,
    output logic        Devsel,
    output logic        Trdy
);

    localparam logic [31:0] FIRST_ADDR = 32'(BASE_ADDR);
    localparam logic [31:0] LAST_ADDR  = 32'(BASE_ADDR + DEPTH - 1);
    localparam int unsigned IDX_W      = idx_width(DEPTH);

    pci_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  cmd_q, cmd_d;
    // Set while an unclaimed transaction is still on the bus, so its data
    // phases (Frame=0) are not mistaken for new address phases.
    logic        ignore_q, ignore_d;

    logic             in_range;
    logic             xfer;
    logic [31:0]      next_addr;
    logic             ad_oe;
    logic             mem_we;
    logic [IDX_W-1:0] mem_addr;
    logic [31:0]      mem_rdata;

    assign in_range  = (AddressData >= FIRST_ADDR) && (AddressData <= LAST_ADDR);
    assign xfer      = ((state_q == ST_WRITE) || (state_q == ST_READ)) && !Irdy;
    assign next_addr = (addr_q == LAST_ADDR) ? FIRST_ADDR : addr_q + 32'd1;
    assign mem_addr  = IDX_W'(addr_q - FIRST_ADDR);

    // State register
    always_ff @(posedge Clock or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            cmd_q    <= '0;
            ignore_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cmd_q    <= cmd_d;
            ignore_q <= ignore_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cmd_d    = cmd_q;
        ignore_d = ignore_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ignore_q) begin
                    if (Frame && Irdy) begin
                        ignore_d = 1'b0;
                    end
                end else if (!Frame) begin
                    addr_d = AddressData;
                    cmd_d  = CBE;
                    if (in_range && (CBE == CMD_MEM_WRITE)) begin
                        state_d = ST_WRITE;
                    end else if (in_range && (CBE == CMD_MEM_READ)) begin
                        state_d = ST_READ_TA;
                    end else begin
                        ignore_d = 1'b1;
                    end
                end
            end
            ST_READ_TA: begin
                state_d = (Frame && Irdy) ? ST_IDLE : ST_READ;
            end
            ST_WRITE, ST_READ: begin
                if (xfer) begin
                    addr_d = next_addr;
                end
                // Either the last transfer or a master abort (Irdy=1).
                if (Frame) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        Devsel = (state_q == ST_IDLE);
        Trdy   = !((state_q == ST_WRITE) || (state_q == ST_READ));
        ad_oe  = (state_q == ST_READ) && (cmd_q == CMD_MEM_READ);
        mem_we = (state_q == ST_WRITE) && !Irdy && (cmd_q == CMD_MEM_WRITE);
    end

    assign AddressData = ad_oe ? mem_rdata : 32'hzzzz_zzzz;

    pci_mem #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk   (Clock),
        .rst   (RST),
        .we    (mem_we),
        .be    (CBE),
        .addr  (mem_addr),
        .wdata (AddressData),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_pci.sv
// -----------------------------------------------------------------------------
// tb_pci
// Directed cycle-by-cycle vectors for the pci target (BASE_ADDR=20, DEPTH=10),
// plus a hand-written asynchronous reset sequence in the middle of a burst.
// A released bus is probed by parking 0 on it from the bench and reading 0.
// -----------------------------------------------------------------------------
module tb_pci;

    typedef struct {
        string       name;
        logic        frame;
        logic        irdy;
        logic [3:0]  cbe;
        logic        oe;
        logic [31:0] ad;
        logic        exp_devsel;
        logic        exp_trdy;
        logic [1:0]  chk;      // 0: none, 1: bus data, 2: bus released
        logic [31:0] exp_ad;
    } vec_t;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        frame  = 1'b1;
    logic        irdy   = 1'b1;
    logic [3:0]  cbe    = 4'b0000;
    logic        tb_oe  = 1'b0;
    logic [31:0] tb_ad  = 32'h0;
    wire  [31:0] ad_bus;
    logic        devsel;
    logic        trdy;

    int errors = 0;
    int checks = 0;
    vec_t tbl[$];
    int n1;

    assign ad_bus = tb_oe ? tb_ad : 32'hzzzz_zzzz;

    pci #(
        .BASE_ADDR (20),
        .DEPTH     (10)
    ) dut (
        .Clock       (clk),
        .RST         (rst),
        .Frame       (frame),
        .AddressData (ad_bus),
        .CBE         (cbe),
        .Irdy        (irdy),
        .Devsel      (devsel),
        .Trdy        (trdy)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input string n, input logic f, input logic i,
                               input logic [3:0] c, input logic oe, input logic [31:0] ad,
                               input logic ed, input logic et, input logic [1:0] k,
                               input logic [31:0] ea);
        vec_t r;
        r.name = n; r.frame = f; r.irdy = i; r.cbe = c; r.oe = oe; r.ad = ad;
        r.exp_devsel = ed; r.exp_trdy = et; r.chk = k; r.exp_ad = ea;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_released(input string name);
        logic        sv_oe;
        logic [31:0] sv_ad;
        sv_oe = tb_oe;
        sv_ad = tb_ad;
        tb_oe = 1'b1;
        tb_ad = 32'h0;
        #1;
        chk(name, ad_bus, 32'h0);
        tb_oe = sv_oe;
        tb_ad = sv_ad;
    endtask

    task automatic apply(input vec_t t);
        @(negedge clk);
        frame = t.frame; irdy = t.irdy; cbe = t.cbe; tb_oe = t.oe; tb_ad = t.ad;
        @(posedge clk);
        #1;
        chk({t.name, " devsel"}, 32'(devsel), 32'(t.exp_devsel));
        chk({t.name, " trdy"}, 32'(trdy), 32'(t.exp_trdy));
        if (t.chk == 2'd1) chk({t.name, " ad"}, ad_bus, t.exp_ad);
        else if (t.chk == 2'd2) check_released({t.name, " ad_z"});
    endtask

    initial begin
        // Burst write 21..23
        tbl.push_back(v("A0", 0, 1, 4'b0111, 1, 32'd21,        0, 0, 0, 0));
        tbl.push_back(v("A1", 0, 0, 4'b1111, 1, 32'h11111111,  0, 0, 0, 0));
        tbl.push_back(v("A2", 0, 0, 4'b1111, 1, 32'h22222222,  0, 0, 0, 0));
        tbl.push_back(v("A3", 1, 0, 4'b1111, 1, 32'h33333333,  1, 1, 2, 0));
        tbl.push_back(v("A4", 1, 1, 4'b0000, 0, 32'h0,         1, 1, 2, 0));
        // Out-of-range and wrong-command transactions are never claimed
        tbl.push_back(v("B0", 0, 1, 4'b0111, 1, 32'd4,         1, 1, 0, 0));
        tbl.push_back(v("B1", 0, 0, 4'b0111, 1, 32'd21,        1, 1, 0, 0));
        tbl.push_back(v("B2", 1, 0, 4'b1111, 1, 32'hDEADBEEF,  1, 1, 2, 0));
        tbl.push_back(v("B3", 1, 1, 4'b0000, 0, 32'h0,         1, 1, 2, 0));
        tbl.push_back(v("B4", 0, 1, 4'b0110, 1, 32'd4,         1, 1, 0, 0));
        tbl.push_back(v("B5", 0, 0, 4'b0000, 0, 32'h0,         1, 1, 2, 0));
        tbl.push_back(v("B6", 1, 0, 4'b0000, 0, 32'h0,         1, 1, 2, 0));
        tbl.push_back(v("B7", 1, 1, 4'b0000, 0, 32'h0,         1, 1, 2, 0));
        tbl.push_back(v("B8", 0, 1, 4'b0111, 1, 32'd30,        1, 1, 0, 0));
        tbl.push_back(v("B9", 1, 0, 4'b1111, 1, 32'hFFFFFFFF,  1, 1, 2, 0));
        tbl.push_back(v("B10", 1, 1, 4'b0000, 0, 32'h0,        1, 1, 2, 0));
        tbl.push_back(v("B11", 0, 1, 4'b0110, 1, 32'd19,       1, 1, 0, 0));
        tbl.push_back(v("B12", 1, 0, 4'b0000, 0, 32'h0,        1, 1, 2, 0));
        tbl.push_back(v("B13", 1, 1, 4'b0000, 0, 32'h0,        1, 1, 2, 0));
        tbl.push_back(v("B14", 0, 1, 4'b0010, 1, 32'd21,       1, 1, 0, 0));
        tbl.push_back(v("B15", 1, 0, 4'b0000, 0, 32'h0,        1, 1, 2, 0));
        tbl.push_back(v("B16", 1, 1, 4'b0000, 0, 32'h0,        1, 1, 2, 0));
        // Burst read 21..23; Trdy lags Devsel by one cycle
        tbl.push_back(v("C0", 0, 1, 4'b0110, 1, 32'd21,        0, 1, 2, 0));
        tbl.push_back(v("C1", 0, 0, 4'b0000, 0, 32'h0,         0, 0, 1, 32'h11111111));
        tbl.push_back(v("C2", 0, 0, 4'b1111, 0, 32'h0,         0, 0, 1, 32'h22222222));
        tbl.push_back(v("C3", 0, 0, 4'b0000, 0, 32'h0,         0, 0, 1, 32'h33333333));
        tbl.push_back(v("C4", 1, 0, 4'b0000, 0, 32'h0,         1, 1, 2, 0));
        // Address wrap from 29 to 20
        tbl.push_back(v("D0", 0, 1, 4'b0111, 1, 32'd29,        0, 0, 0, 0));
        tbl.push_back(v("D1", 0, 0, 4'b1111, 1, 32'hAAAA0029,  0, 0, 0, 0));
        tbl.push_back(v("D2", 1, 0, 4'b1111, 1, 32'hAAAA0020,  1, 1, 2, 0));
        tbl.push_back(v("D3", 1, 1, 4'b0000, 0, 32'h0,         1, 1, 2, 0));
        tbl.push_back(v("D4", 0, 1, 4'b0110, 1, 32'd29,        0, 1, 2, 0));
        tbl.push_back(v("D5", 0, 0, 4'b0000, 0, 32'h0,         0, 0, 1, 32'hAAAA0029));
        tbl.push_back(v("D6", 0, 0, 4'b0000, 0, 32'h0,         0, 0, 1, 32'hAAAA0020));
        tbl.push_back(v("D7", 1, 0, 4'b0000, 0, 32'h0,         1, 1, 2, 0));
        // Write wait state, then read with a wait state
        tbl.push_back(v("E0", 0, 1, 4'b0111, 1, 32'd21,        0, 0, 0, 0));
        tbl.push_back(v("E1", 0, 0, 4'b1111, 1, 32'h0A0A0A0A,  0, 0, 0, 0));
        tbl.push_back(v("E2", 0, 1, 4'b1111, 1, 32'hBAD0BAD0,  0, 0, 0, 0));
        tbl.push_back(v("E3", 1, 0, 4'b1111, 1, 32'h0B0B0B0B,  1, 1, 2, 0));
        tbl.push_back(v("E4", 1, 1, 4'b0000, 0, 32'h0,         1, 1, 2, 0));
        tbl.push_back(v("E5", 0, 1, 4'b0110, 1, 32'd21,        0, 1, 2, 0));
        tbl.push_back(v("E6", 0, 1, 4'b0000, 0, 32'h0,         0, 0, 1, 32'h0A0A0A0A));
        tbl.push_back(v("E7", 0, 1, 4'b0000, 0, 32'h0,         0, 0, 1, 32'h0A0A0A0A));
        tbl.push_back(v("E8", 0, 0, 4'b0000, 0, 32'h0,         0, 0, 1, 32'h0B0B0B0B));
        tbl.push_back(v("E9", 0, 0, 4'b0000, 0, 32'h0,         0, 0, 1, 32'h33333333));
        tbl.push_back(v("E10", 1, 0, 4'b0000, 0, 32'h0,        1, 1, 2, 0));
        tbl.push_back(v("E11", 1, 1, 4'b0000, 0, 32'h0,        1, 1, 2, 0));
        // Master abort on a write: no data lands at 25
        tbl.push_back(v("F0", 0, 1, 4'b0111, 1, 32'd25,        0, 0, 0, 0));
        tbl.push_back(v("F1", 1, 1, 4'b1111, 1, 32'h12345678,  1, 1, 2, 0));
        tbl.push_back(v("F2", 0, 1, 4'b0110, 1, 32'd25,        0, 1, 2, 0));
        tbl.push_back(v("F3", 1, 0, 4'b0000, 0, 32'h0,         0, 0, 1, 32'h0));
        tbl.push_back(v("F4", 1, 0, 4'b0000, 0, 32'h0,         1, 1, 2, 0));
        n1 = tbl.size();
        // After reset: byte-enabled writes, empty BE, single data phase
        tbl.push_back(v("G0", 0, 1, 4'b0111, 1, 32'd21,        0, 0, 0, 0));
        tbl.push_back(v("G1", 0, 0, 4'b1000, 1, 32'h33333333,  0, 0, 0, 0));
        tbl.push_back(v("G2", 0, 0, 4'b0001, 1, 32'h33333333,  0, 0, 0, 0));
        tbl.push_back(v("G3", 1, 0, 4'b0010, 1, 32'h33333333,  1, 1, 2, 0));
        tbl.push_back(v("G4", 1, 1, 4'b0000, 0, 32'h0,         1, 1, 2, 0));
        tbl.push_back(v("G5", 0, 1, 4'b0110, 1, 32'd21,        0, 1, 2, 0));
        tbl.push_back(v("G6", 0, 0, 4'b0000, 0, 32'h0,         0, 0, 1, 32'h33000000));
        tbl.push_back(v("G7", 0, 0, 4'b0000, 0, 32'h0,         0, 0, 1, 32'h00000033));
        tbl.push_back(v("G8", 0, 0, 4'b0000, 0, 32'h0,         0, 0, 1, 32'h00003300));
        tbl.push_back(v("G9", 1, 0, 4'b0000, 0, 32'h0,         1, 1, 2, 0));
        tbl.push_back(v("G10", 1, 1, 4'b0000, 0, 32'h0,        1, 1, 2, 0));
        tbl.push_back(v("H0", 0, 1, 4'b0111, 1, 32'd24,        0, 0, 0, 0));
        tbl.push_back(v("H1", 1, 0, 4'b0000, 1, 32'hFFFFFFFF,  1, 1, 2, 0));
        tbl.push_back(v("H2", 1, 1, 4'b0000, 0, 32'h0,         1, 1, 2, 0));
        tbl.push_back(v("H3", 0, 1, 4'b0111, 1, 32'd21,        0, 0, 0, 0));
        tbl.push_back(v("H4", 1, 0, 4'b1111, 1, 32'h33333333,  1, 1, 2, 0));
        tbl.push_back(v("H5", 1, 1, 4'b0000, 0, 32'h0,         1, 1, 2, 0));
        tbl.push_back(v("H6", 0, 1, 4'b0110, 1, 32'd21,        0, 1, 2, 0));
        tbl.push_back(v("H7", 0, 0, 4'b0000, 0, 32'h0,         0, 0, 1, 32'h33333333));
        tbl.push_back(v("H8", 0, 0, 4'b0000, 0, 32'h0,         0, 0, 1, 32'h00000033));
        tbl.push_back(v("H9", 0, 0, 4'b0000, 0, 32'h0,         0, 0, 1, 32'h00003300));
        tbl.push_back(v("H10", 0, 0, 4'b0000, 0, 32'h0,        0, 0, 1, 32'h00000000));
        tbl.push_back(v("H11", 1, 0, 4'b0000, 0, 32'h0,        1, 1, 2, 0));

        // Reset state before any clock edge
        #2;
        chk("reset devsel", 32'(devsel), 32'd1);
        chk("reset trdy", 32'(trdy), 32'd1);
        check_released("reset ad_z");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < n1; i++) apply(tbl[i]);

        // Asynchronous reset in the middle of a write burst to 21
        apply(v("R0", 0, 1, 4'b0111, 1, 32'd21,       0, 0, 0, 0));
        apply(v("R1", 0, 0, 4'b1111, 1, 32'h5555AAAA, 0, 0, 0, 0));
        @(negedge clk);
        frame = 1'b0; irdy = 1'b0; cbe = 4'b1111; tb_oe = 1'b1; tb_ad = 32'h6666BBBB;
        #2;
        rst = 1'b1;
        #1;
        chk("R2 async devsel", 32'(devsel), 32'd1);
        chk("R2 async trdy", 32'(trdy), 32'd1);
        check_released("R2 async ad_z");
        // Frame still low at release: the interrupted burst must not resume
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("R3 devsel", 32'(devsel), 32'd1);
        chk("R3 trdy", 32'(trdy), 32'd1);
        apply(v("R4", 1, 1, 4'b0000, 0, 32'h0,  1, 1, 2, 0));
        apply(v("R5", 0, 1, 4'b0110, 1, 32'd21, 0, 1, 2, 0));
        apply(v("R6", 0, 0, 4'b0000, 0, 32'h0,  0, 0, 1, 32'h0));
        apply(v("R7", 0, 0, 4'b0000, 0, 32'h0,  0, 0, 1, 32'h0));
        apply(v("R8", 0, 0, 4'b0000, 0, 32'h0,  0, 0, 1, 32'h0));
        apply(v("R9", 1, 0, 4'b0000, 0, 32'h0,  1, 1, 2, 0));
        apply(v("R10", 1, 1, 4'b0000, 0, 32'h0, 1, 1, 2, 0));

        for (int i = n1; i < tbl.size(); i++) apply(tbl[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
